// File: rtl/csr_pkg.sv
// Shared CSR address constants, write-back op encoding and the read-modify-write
// helper used by the counter bank.
package csr_pkg;

  localparam logic [11:0] CSR_USER_BASE     = 12'hC00;
  localparam logic [11:0] CSR_MACH_BASE     = 12'hB00;
  localparam logic [11:0] CSR_HI_OFFSET     = 12'h080;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

  // Index of each counter inside a 32-entry C/B page; hpm i sits at IDX_HPM0 + i.
  localparam int IDX_CYCLE   = 0;
  localparam int IDX_TIME    = 1;
  localparam int IDX_INSTRET = 2;
  localparam int IDX_HPM0    = 3;

  typedef enum logic [1:0] {
    WB_NONE  = 2'b00,
    WB_CLEAR = 2'b01,
    WB_SET   = 2'b10,
    WB_WRITE = 2'b11
  } csr_wb_op_e;

  function automatic logic [31:0] apply_op(input logic [31:0] old,
                                           input logic [31:0] data,
                                           input csr_wb_op_e  op);
    case (op)
      WB_CLEAR: return old & ~data;
      WB_SET:   return old | data;
      WB_WRITE: return data;
      default:  return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter.sv
// One CNT_WIDTH-bit event counter whose XLEN-bit halves can be overwritten;
// a write in the same cycle as an increment wins and suppresses the increment.
module csr_counter #(
  parameter int CNT_WIDTH = 64,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 inhibit,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [XLEN-1:0]      wr_data,
  output logic [CNT_WIDTH-1:0] value
);

  localparam int HI_WIDTH = CNT_WIDTH - XLEN;

  // NOTE: state is updated with <= so every register samples pre-edge values,
  // which is what makes the read path see the value from before a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (wr_lo) begin
      value <= {value[CNT_WIDTH-1:XLEN], wr_data};
    end else if (wr_hi) begin
      value <= {wr_data[HI_WIDTH-1:0], value[XLEN-1:0]};
    end else if (inc && !inhibit) begin
      value <= value + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/csr_counter_bank.sv
// Zicntr/Zihpm counter bank: cycle, instret and NUM_HPM event counters with
// mcountinhibit, a registered read port and per-access illegal flags.
module csr_counter_bank
  import csr_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_HPM   = 4,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read,
  input  logic [11:0]          read_address,
  output logic [XLEN-1:0]      read_data,
  output logic                 read_valid,
  output logic                 read_illegal,
  input  logic [1:0]           write_back,
  input  logic [11:0]          write_back_address,
  input  logic [XLEN-1:0]      write_back_data,
  output logic                 write_illegal,
  input  logic                 increment_instret,
  input  logic [NUM_HPM-1:0]   hpm_event,
  input  logic [CNT_WIDTH-1:0] time_value
);

  // Counter slot k: 0 = cycle, 1 = instret, 2+i = hpm i.
  localparam int NUM_CNT = 2 + NUM_HPM;
  localparam logic [XLEN-1:0] INHIBIT_MASK =
    XLEN'(32'h5) | (XLEN'((64'd1 << NUM_HPM) - 64'd1) << IDX_HPM0);

  function automatic int slot_index(input int k);
    return (k == 0) ? IDX_CYCLE : k + 1;
  endfunction

  logic [63:0]        cnt_ext [NUM_CNT];
  logic [63:0]        time_ext;
  logic [NUM_CNT-1:0] cnt_inc, cnt_wr_lo, cnt_wr_hi;
  logic [XLEN-1:0]    mcountinhibit;

  csr_wb_op_e      wb_op;
  int              wb_idx, rd_idx;
  logic            wb_active, wb_hi, wb_counter_addr, wb_inh_addr, wb_illegal;
  logic [XLEN-1:0] wb_old, wb_new;
  logic            rd_hi, rd_user, rd_window, rd_legal;
  logic [XLEN-1:0] rd_value;

  assign cnt_inc  = {hpm_event, increment_instret, 1'b1};
  assign time_ext = 64'(time_value);

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    logic [CNT_WIDTH-1:0] value;
    csr_counter #(.CNT_WIDTH(CNT_WIDTH), .XLEN(XLEN)) u_counter (
      .clk     (clk),
      .rst     (rst),
      .inc     (cnt_inc[k]),
      .inhibit (mcountinhibit[(k == 0) ? IDX_CYCLE : k + 1]),
      .wr_lo   (cnt_wr_lo[k]),
      .wr_hi   (cnt_wr_hi[k]),
      .wr_data (wb_new),
      .value   (value)
    );
    assign cnt_ext[k] = 64'(value);
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    wb_op           = csr_wb_op_e'(write_back);
    wb_active       = (wb_op != WB_NONE);
    wb_idx          = int'(write_back_address[4:0]);
    wb_hi           = write_back_address[7];
    wb_inh_addr     = (write_back_address == CSR_MCOUNTINHIBIT);
    wb_counter_addr = (write_back_address[11:8] == CSR_MACH_BASE[11:8]) &&
                      (write_back_address[6:5] == 2'b00) &&
                      (wb_idx == IDX_CYCLE ||
                       (wb_idx >= IDX_INSTRET && wb_idx < IDX_HPM0 + NUM_HPM));
    wb_old    = '0;
    cnt_wr_lo = '0;
    cnt_wr_hi = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (slot_index(k) == wb_idx) begin
        wb_old       = wb_hi ? cnt_ext[k][63:32] : cnt_ext[k][31:0];
        cnt_wr_lo[k] = wb_active && wb_counter_addr && !wb_hi;
        cnt_wr_hi[k] = wb_active && wb_counter_addr && wb_hi;
      end
    end
    wb_new = apply_op(wb_old, write_back_data, wb_op);
    // mcountinhibit accepts its implemented bits even when the flag is raised.
    wb_illegal = wb_active && !wb_counter_addr &&
                 !(wb_inh_addr && ((write_back_data & ~INHIBIT_MASK) == '0));
  end

  always_comb begin
    rd_idx    = int'(read_address[4:0]);
    rd_hi     = read_address[7];
    rd_user   = (read_address[11:8] == CSR_USER_BASE[11:8]);
    rd_window = (rd_user || read_address[11:8] == CSR_MACH_BASE[11:8]) &&
                (read_address[6:5] == 2'b00);
    rd_legal  = 1'b0;
    rd_value  = '0;
    if (read_address == CSR_MCOUNTINHIBIT) begin
      rd_legal = 1'b1;
      rd_value = mcountinhibit;
    end else if (rd_window) begin
      if (rd_user && rd_idx == IDX_TIME) begin
        rd_legal = 1'b1;
        rd_value = rd_hi ? time_ext[63:32] : time_ext[31:0];
      end
      for (int k = 0; k < NUM_CNT; k++) begin
        if (slot_index(k) == rd_idx) begin
          rd_legal = 1'b1;
          rd_value = rd_hi ? cnt_ext[k][63:32] : cnt_ext[k][31:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcountinhibit <= '0;
    end else if (wb_active && wb_inh_addr) begin
      mcountinhibit <= apply_op(mcountinhibit, write_back_data, wb_op) & INHIBIT_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_data     <= '0;
      read_valid    <= 1'b0;
      read_illegal  <= 1'b0;
      write_illegal <= 1'b0;
    end else begin
      read_data     <= (read && rd_legal) ? rd_value : '0;
      read_valid    <= read;
      read_illegal  <= read && !rd_legal;
      write_illegal <= wb_illegal;
    end
  end

endmodule

// File: tb/tb_csr_counter_bank.sv
// Self-checking bench for csr_counter_bank (NUM_HPM=4, CNT_WIDTH=40): read
// expectations go through a scoreboard queue, legality/RMW cases come from a table.
module tb_csr_counter_bank;
  import csr_pkg::*;

  localparam int XLEN      = 32;
  localparam int NUM_HPM   = 4;
  localparam int CNT_WIDTH = 40;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 read;
  logic [11:0]          read_address;
  logic [XLEN-1:0]      read_data;
  logic                 read_valid;
  logic                 read_illegal;
  logic [1:0]           write_back;
  logic [11:0]          write_back_address;
  logic [XLEN-1:0]      write_back_data;
  logic                 write_illegal;
  logic                 increment_instret;
  logic [NUM_HPM-1:0]   hpm_event;
  logic [CNT_WIDTH-1:0] time_value;

  csr_counter_bank #(.XLEN(XLEN), .NUM_HPM(NUM_HPM), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .read               (read),
    .read_address       (read_address),
    .read_data          (read_data),
    .read_valid         (read_valid),
    .read_illegal       (read_illegal),
    .write_back         (write_back),
    .write_back_address (write_back_address),
    .write_back_data    (write_back_data),
    .write_illegal      (write_illegal),
    .increment_instret  (increment_instret),
    .hpm_event          (hpm_event),
    .time_value         (time_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        illegal;
  } rd_exp_t;

  typedef struct {
    csr_wb_op_e  op;
    logic [11:0] wa;
    logic [31:0] wd;
    logic        exp_wi;
    logic [11:0] ra;
    logic [31:0] exp_rd;
    logic        exp_ri;
  } vec_t;

  rd_exp_t sb_q[$];
  vec_t    tbl[$];
  logic    exp_wi;
  int      checks   = 0;
  int      failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock, then compare the outputs produced by that edge.
  task automatic step(input string name);
    rd_exp_t e;
    @(posedge clk);
    #1;
    check({name, " write_illegal"}, 32'(write_illegal), 32'(exp_wi));
    exp_wi = 1'b0;
    check({name, " read_valid"}, 32'(read_valid), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (read_valid === 1'b1) begin
        check({e.name, " data"}, read_data, e.data);
        check({e.name, " illegal"}, 32'(read_illegal), 32'(e.illegal));
      end
    end
  endtask

  task automatic do_read(input logic [11:0] addr, input logic [31:0] exp_data,
                         input logic exp_ill, input string name);
    rd_exp_t e;
    e.name = name; e.data = exp_data; e.illegal = exp_ill;
    read = 1'b1;
    read_address = addr;
    sb_q.push_back(e);
    step(name);
    read = 1'b0;
  endtask

  task automatic do_write(input csr_wb_op_e op, input logic [11:0] addr,
                          input logic [31:0] data, input logic exp_ill, input string name);
    write_back         = op;
    write_back_address = addr;
    write_back_data    = data;
    exp_wi             = exp_ill;
    step(name);
    write_back = WB_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tbl.push_back('{WB_WRITE, 12'hB03, 32'hDEADBEEF, 1'b0, 12'hC03, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{WB_WRITE, 12'hB83, 32'hFFFFFFFF, 1'b0, 12'hC83, 32'h000000FF, 1'b0});
    tbl.push_back('{WB_SET,   12'hB04, 32'h000000F0, 1'b0, 12'hB04, 32'h000000F0, 1'b0});
    tbl.push_back('{WB_CLEAR, 12'hB03, 32'h0000FFFF, 1'b0, 12'hC03, 32'hDEAD0000, 1'b0});
    tbl.push_back('{WB_SET,   12'hB84, 32'h00000100, 1'b0, 12'hC84, 32'h00000000, 1'b0});
    tbl.push_back('{WB_WRITE, 12'hB86, 32'h000000AB, 1'b0, 12'hC86, 32'h000000AB, 1'b0});
    tbl.push_back('{WB_WRITE, 12'hC03, 32'h00000001, 1'b1, 12'hC03, 32'hDEAD0000, 1'b0});
    tbl.push_back('{WB_WRITE, 12'hB01, 32'h00000005, 1'b1, 12'hB01, 32'h00000000, 1'b1});
    tbl.push_back('{WB_WRITE, 12'hB07, 32'h00000005, 1'b1, 12'hC07, 32'h00000000, 1'b1});
    tbl.push_back('{WB_NONE,  12'hC00, 32'hFFFFFFFF, 1'b0, 12'hC1F, 32'h00000000, 1'b1});
    tbl.push_back('{WB_WRITE, 12'h320, 32'h00000002, 1'b1, 12'h320, 32'h00000000, 1'b0});
    tbl.push_back('{WB_WRITE, 12'h320, 32'h00000078, 1'b0, 12'h320, 32'h00000078, 1'b0});
    tbl.push_back('{WB_WRITE, 12'h320, 32'h80000001, 1'b1, 12'h320, 32'h00000001, 1'b0});
    tbl.push_back('{WB_WRITE, 12'h320, 32'h00000000, 1'b0, 12'hC81, 32'h00000012, 1'b0});
    tbl.push_back('{WB_NONE,  12'h000, 32'h00000000, 1'b0, 12'hC01, 32'h3456789A, 1'b0});
    tbl.push_back('{WB_NONE,  12'h000, 32'h00000000, 1'b0, 12'h123, 32'h00000000, 1'b1});
    tbl.push_back('{WB_NONE,  12'h000, 32'h00000000, 1'b0, 12'hB81, 32'h00000000, 1'b1});
    tbl.push_back('{WB_WRITE, 12'h123, 32'h00000001, 1'b1, 12'hB83, 32'h000000FF, 1'b0});

    rst = 1'b1; read = 1'b0; read_address = '0;
    write_back = WB_NONE; write_back_address = '0; write_back_data = '0;
    increment_instret = 1'b0; hpm_event = '0; time_value = 40'h12_3456_789A;
    exp_wi = 1'b0;

    // Reset state, then cycle counts 10 idle cycles.
    step("reset0");
    step("reset1");
    check("reset read_data", read_data, 32'h0);
    check("reset read_illegal", 32'(read_illegal), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step("idle");
    do_read(12'hC00, 32'd10, 1'b0, "cycle lo after idle");
    do_read(12'hC80, 32'd0, 1'b0, "cycle hi after idle");

    // Carry from lo into hi lands exactly one increment after the write.
    do_write(WB_WRITE, 12'hB80, 32'h00000001, 1'b0, "mcycle hi wr");
    do_write(WB_WRITE, 12'hB00, 32'hFFFFFFFF, 1'b0, "mcycle lo wr");
    do_read(12'hC00, 32'hFFFFFFFF, 1'b0, "cycle lo raw");
    do_read(12'hC80, 32'h00000002, 1'b0, "cycle hi carried");
    do_read(12'hC00, 32'h00000001, 1'b0, "cycle lo after wrap");

    foreach (tbl[i]) begin
      do_write(tbl[i].op, tbl[i].wa, tbl[i].wd, tbl[i].exp_wi, $sformatf("vec%0d wr", i));
      do_read(tbl[i].ra, tbl[i].exp_rd, tbl[i].exp_ri, $sformatf("vec%0d rd", i));
    end

    // Write beats a simultaneous increment; then set/clear on the result.
    increment_instret = 1'b1;
    do_write(WB_WRITE, 12'hB02, 32'h00001234, 1'b0, "minstret wr+inc");
    increment_instret = 1'b0;
    do_read(12'hC02, 32'h00001234, 1'b0, "instret write wins");
    do_write(WB_SET, 12'hB02, 32'h000000F0, 1'b0, "minstret set");
    do_read(12'hC02, 32'h000012F4, 1'b0, "instret after set");
    do_write(WB_CLEAR, 12'hB02, 32'h000000F0, 1'b0, "minstret clear");
    do_read(12'hC02, 32'h00001204, 1'b0, "instret after clear");

    // Inhibit takes effect from the cycle after the mcountinhibit write.
    increment_instret = 1'b1;
    do_write(WB_SET, 12'h320, 32'h00000004, 1'b0, "inhibit IR set");
    for (int i = 0; i < 5; i++) step("inhibited inc");
    increment_instret = 1'b0;
    do_read(12'hC02, 32'h00001205, 1'b0, "instret while inhibited");
    increment_instret = 1'b1;
    do_write(WB_CLEAR, 12'h320, 32'h00000004, 1'b0, "inhibit IR clear");
    for (int i = 0; i < 3; i++) step("resumed inc");
    increment_instret = 1'b0;
    do_read(12'hC02, 32'h00001208, 1'b0, "instret resumed +3");

    // hpm0 wraps to zero at 2^40; hpm1 counts during hpm0's write cycle.
    hpm_event = 4'b0001;
    do_write(WB_WRITE, 12'hB83, 32'h000000FF, 1'b0, "mhpm0 hi wr");
    hpm_event = 4'b0011;
    do_write(WB_WRITE, 12'hB03, 32'hFFFFFFFE, 1'b0, "mhpm0 lo wr");
    hpm_event = 4'b0001;
    do_read(12'hC03, 32'hFFFFFFFE, 1'b0, "hpm0 lo pre-wrap");
    do_read(12'hC83, 32'h000000FF, 1'b0, "hpm0 hi pre-wrap");
    hpm_event = 4'b0000;
    do_read(12'hC03, 32'h00000000, 1'b0, "hpm0 lo wrapped");
    do_read(12'hC83, 32'h00000000, 1'b0, "hpm0 hi wrapped");
    do_read(12'hC04, 32'h000000F1, 1'b0, "hpm1 counted alongside");

    // Reset with a read and a write in flight.
    do_write(WB_WRITE, 12'h320, 32'h00000005, 1'b0, "inhibit pre-reset");
    do_write(WB_WRITE, 12'hC00, 32'h00000001, 1'b1, "illegal pre-reset");
    rst = 1'b1;
    read = 1'b1; read_address = 12'hC00;
    write_back = WB_WRITE; write_back_address = 12'hB02; write_back_data = 32'h55;
    step("reset mid-op");
    check("mid reset read_data", read_data, 32'h0);
    check("mid reset read_illegal", 32'(read_illegal), 32'h0);
    rst = 1'b0; read = 1'b0; write_back = WB_NONE;
    do_read(12'hC02, 32'h0, 1'b0, "instret after reset");
    do_read(12'h320, 32'h0, 1'b0, "inhibit after reset");
    do_read(12'hC00, 32'd2, 1'b0, "cycle after reset");
    do_read(12'hC80, 32'd0, 1'b0, "cycle hi after reset");
    do_read(12'hC03, 32'h0, 1'b0, "hpm0 after reset");
    step("drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
